// File: rtl/alu_sequencer.sv
// Instruction sequencer that owns a 16-entry register file and drives an external
// combinational ALU through an IDLE -> ISSUE -> CAPTURE -> RESP handshake.
module alu_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ins_valid,
  output logic         ins_ready,
  input  logic [15:0]  ins,
  input  logic         ld_en,
  input  logic [3:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  output logic [3:0]   alu_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_op,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic [3:0]   res_dst,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   rf_q [16];
  logic [3:0]     alu_sel_q, alu_sel_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic [3:0]     res_dst_q, res_dst_d;
  logic           res_valid_q, res_valid_d;
  logic           accept_s;
  logic           capture_s;

  assign accept_s  = ins_valid && (state_q == S_IDLE);
  assign capture_s = (state_q == S_CAPTURE);

  assign ins_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_data  = res_data_q;
  assign res_dst   = res_dst_q;
  assign res_valid = res_valid_q;

  // Next-state logic for the instruction handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ins_valid) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand/result datapath; ALU drive registers hold their value outside accept.
  always_comb begin
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_data_d  = res_data_q;
    res_dst_d   = res_dst_q;
    res_valid_d = res_valid_q;
    if (accept_s) begin
      // Reads see the register file before any same-edge load lands.
      alu_sel_d = ins[15:12];
      alu_a_d   = rf_q[ins[7:4]];
      alu_b_d   = rf_q[ins[3:0]];
      res_dst_d = ins[11:8];
    end else begin
      alu_sel_d = alu_sel_q;
    end
    if (capture_s) begin
      res_data_d  = alu_op;
      res_valid_d = 1'b1;
    end else if ((state_q == S_RESP) && res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_sel_q   <= 4'd0;
      alu_a_q     <= {W{1'b0}};
      alu_b_q     <= {W{1'b0}};
      res_data_q  <= {W{1'b0}};
      res_dst_q   <= 4'd0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_data_q  <= res_data_d;
      res_dst_q   <= res_dst_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Register file: the write-back is assigned last so it beats a load to the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= {W{1'b0}};
      end
    end else begin
      if (ld_en) begin
        rf_q[ld_addr] <= ld_data;
      end
      if (capture_s) begin
        rf_q[res_dst_q] <= alu_op;
      end
    end
  end

endmodule
